// File: rtl/lvds71_tx_framer.sv
// Purpose : packs 24-bit RGB + HS/VS/DE pixels into four 7-bit LVDS data-lane words plus
//           the clock-lane word. A fixed training word is sent after reset or on retrain.
// Latency : a pixel pushed into an empty FIFO while in RUN is on txd0..3 one SCLK edge later.
// Backpr. : in_ready = !full & !retrain. Pixels queue during TRAIN. An empty FIFO in RUN
//           emits a blanking word and sets the sticky underflow flag.
//
// Ports
//   SCLK, RSTB        word clock (serializer SCLK); synchronous active-high reset
//   retrain           one-cycle request: flush FIFO, clear flags, restart TRAIN
//   in_valid/in_ready pixel handshake; in_rgb = {R,G,B}; in_hs/in_vs/in_de sync and enable
//   txd0..txd3        registered data-lane words, bit k drives serializer input Dk
//   txclk             registered clock-lane word (constant 7'b1100011)
//   trained           high while in RUN
//   underflow         sticky: RUN found the FIFO empty
module lvds71_tx_framer #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned TRAIN_CYCLES = 1024,
  parameter logic [6:0]  TRAIN_WORD   = 7'b1100011
) (
  input  logic        SCLK,
  input  logic        RSTB,
  input  logic        retrain,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_rgb,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic        in_de,
  output logic [6:0]  txd0,
  output logic [6:0]  txd1,
  output logic [6:0]  txd2,
  output logic [6:0]  txd3,
  output logic [6:0]  txclk,
  output logic        trained,
  output logic        underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (TRAIN_CYCLES > 1) ? $clog2(TRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TRAIN_CYCLES - 1);
  localparam logic [6:0] CLK_WORD = 7'b1100011;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } pix_t;

  typedef enum logic {
    S_TRAIN = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  // Lane words are kept as one bus, ordered {txd3, txd2, txd1, txd0}.
  function automatic logic [27:0] pack(input pix_t p);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [6:0] l0;
    logic [6:0] l1;
    logic [6:0] l2;
    logic [6:0] l3;
    r  = p.rgb[23:16];
    g  = p.rgb[15:8];
    b  = p.rgb[7:0];
    l0 = {g[0], r[5:0]};
    l1 = {b[1], b[0], g[5:1]};
    l2 = {p.de, p.vs, p.hs, b[5:2]};
    l3 = {1'b0, b[7], b[6], g[7], g[6], r[7], r[6]};
    return {l3, l2, l1, l0};
  endfunction

  // ---------------------------------------------------------------------------
  // Pixel FIFO: pointers carry an extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------------
  pix_t          mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          flush;
  pix_t          head;
  pix_t          pix_in;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full && !retrain;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign pix_in   = '{rgb: in_rgb, hs: in_hs, vs: in_vs, de: in_de};

  // Storage needs no reset; validity is carried entirely by the pointers.
  always_ff @(posedge SCLK) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= pix_in;
    end
  end

  always_ff @(posedge SCLK) begin
    if (RSTB || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // TRAIN/RUN control and lane registers
  // ---------------------------------------------------------------------------
  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [27:0]   lanes_q;
  logic [27:0]   lanes_d;
  logic          uf_q;
  logic          uf_d;
  logic          last_hs_q;
  logic          last_hs_d;
  logic          last_vs_q;
  logic          last_vs_d;
  logic [6:0]    txclk_q;
  pix_t          blank;

  // Blanking keeps the last sync levels so the sink does not see a spurious edge.
  assign blank = '{rgb: 24'd0, hs: last_hs_q, vs: last_vs_q, de: 1'b0};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lanes_d   = lanes_q;
    uf_d      = uf_q;
    last_hs_d = last_hs_q;
    last_vs_d = last_vs_q;
    pop       = 1'b0;
    flush     = 1'b0;

    if (retrain) begin
      // Retrain wins over any push or pop in the same cycle.
      state_d   = S_TRAIN;
      cnt_d     = '0;
      lanes_d   = {4{TRAIN_WORD}};
      uf_d      = 1'b0;
      last_hs_d = 1'b0;
      last_vs_d = 1'b0;
      flush     = 1'b1;
    end else begin
      case (state_q)
        S_TRAIN: begin
          lanes_d = {4{TRAIN_WORD}};
          if (cnt_q == CNT_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!empty) begin
            pop       = 1'b1;
            lanes_d   = pack(head);
            last_hs_d = head.hs;
            last_vs_d = head.vs;
          end else begin
            lanes_d = pack(blank);
            uf_d    = 1'b1;
          end
        end
        default: begin
          state_d = S_TRAIN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge SCLK) begin
    if (RSTB) begin
      state_q   <= S_TRAIN;
      cnt_q     <= '0;
      lanes_q   <= {4{TRAIN_WORD}};
      uf_q      <= 1'b0;
      last_hs_q <= 1'b0;
      last_vs_q <= 1'b0;
      txclk_q   <= CLK_WORD;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lanes_q   <= lanes_d;
      uf_q      <= uf_d;
      last_hs_q <= last_hs_d;
      last_vs_q <= last_vs_d;
      txclk_q   <= CLK_WORD;
    end
  end

  assign txd0      = lanes_q[6:0];
  assign txd1      = lanes_q[13:7];
  assign txd2      = lanes_q[20:14];
  assign txd3      = lanes_q[27:21];
  assign txclk     = txclk_q;
  assign trained   = (state_q == S_RUN);
  assign underflow = uf_q;

endmodule

// File: tb/tb_lvds71_tx_framer.sv
module tb_lvds71_tx_framer;

  localparam int TC = 8;
  localparam logic [6:0] TW = 7'b1100011;

  logic        SCLK = 1'b0;
  logic        RSTB = 1'b1;
  logic        retrain = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_rgb = 24'd0;
  logic        in_hs = 1'b0;
  logic        in_vs = 1'b0;
  logic        in_de = 1'b0;
  logic [6:0]  txd0, txd1, txd2, txd3, txclk;
  logic        trained, underflow;

  lvds71_tx_framer #(.FIFO_DEPTH(4), .TRAIN_CYCLES(TC), .TRAIN_WORD(TW)) dut (
    .SCLK(SCLK), .RSTB(RSTB), .retrain(retrain),
    .in_valid(in_valid), .in_ready(in_ready), .in_rgb(in_rgb),
    .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
    .txd0(txd0), .txd1(txd1), .txd2(txd2), .txd3(txd3),
    .txclk(txclk), .trained(trained), .underflow(underflow)
  );

  always #5 SCLK = ~SCLK;

  int cyc = 0;
  always @(posedge SCLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference packing written bit by bit from the lane tables, result {txd3,txd2,txd1,txd0}.
  function automatic logic [27:0] model_pack(input logic [23:0] rgb, input logic hs,
                                             input logic vs, input logic de);
    logic [7:0] r, g, b;
    logic [6:0] l0, l1, l2, l3;
    r = rgb[23:16]; g = rgb[15:8]; b = rgb[7:0];
    for (int k = 0; k < 6; k++) l0[k] = r[k];
    l0[6] = g[0];
    for (int k = 0; k < 5; k++) l1[k] = g[k+1];
    l1[5] = b[0]; l1[6] = b[1];
    for (int k = 0; k < 4; k++) l2[k] = b[k+2];
    l2[4] = hs; l2[5] = vs; l2[6] = de;
    l3[0] = r[6]; l3[1] = r[7]; l3[2] = g[6]; l3[3] = g[7];
    l3[4] = b[6]; l3[5] = b[7]; l3[6] = 1'b0;
    return {l3, l2, l1, l0};
  endfunction

  typedef struct {
    logic [27:0] w;
    logic        hs;
    logic        vs;
    int          tag;   // edge at which the pixel entered the FIFO
  } exp_t;

  exp_t sb[$];
  bit   flush_pending = 1'b0;

  // One input cycle: drive after the edge, decide acceptance just before the next edge.
  task automatic drive(input logic v, input logic [23:0] rgb, input logic hs, input logic vs,
                       input logic de, input logic [27:0] w, input logic rt, input logic rst,
                       output bit acc);
    exp_t e;
    @(posedge SCLK); #1;
    if (flush_pending) sb.delete();
    in_valid = v; in_rgb = rgb; in_hs = hs; in_vs = vs; in_de = de;
    retrain = rt; RSTB = rst;
    flush_pending = rt | rst;
    @(negedge SCLK); #1;
    acc = v && in_ready && !rst;
    if (acc) begin
      e.w = w; e.hs = hs; e.vs = vs; e.tag = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0, 1'b0, acc);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: every edge loads a lane word; predict it from a TRAIN/RUN model and
  // the scoreboard of accepted pixels.
  // ---------------------------------------------------------------------------
  logic        p_rst = 1'b1;
  logic        p_rt = 1'b0;
  bit          m_run = 1'b0;
  int          m_cnt = 0;
  logic        m_uf = 1'b0;
  logic        m_hs = 1'b0;
  logic        m_vs = 1'b0;
  logic [27:0] exp_w;

  always @(negedge SCLK) begin
    exp_t e;
    if (p_rst || p_rt) begin
      m_run = 1'b0; m_cnt = 0; m_uf = 1'b0; m_hs = 1'b0; m_vs = 1'b0;
      exp_w = {4{TW}};
    end else if (!m_run) begin
      exp_w = {4{TW}};
      if (m_cnt == TC - 1) m_run = 1'b1;
      else m_cnt++;
    end else if (sb.size() > 0 && sb[0].tag < cyc) begin
      e = sb.pop_front();
      exp_w = e.w; m_hs = e.hs; m_vs = e.vs;
    end else begin
      exp_w = {7'd0, 1'b0, m_vs, m_hs, 4'd0, 14'd0};
      m_uf = 1'b1;
    end
    chk("txd", {4'd0, txd3, txd2, txd1, txd0}, {4'd0, exp_w});
    chk("txclk", {25'd0, txclk}, {25'd0, 7'b1100011});
    chk("trained", {31'd0, trained}, {31'd0, m_run});
    chk("underflow", {31'd0, underflow}, {31'd0, m_uf});
    p_rst = RSTB;
    p_rt  = retrain;
  end

  // Preload vectors with hand-computed lane words {txd3,txd2,txd1,txd0}, DE=1, HS=VS=0.
  logic [23:0] pre_rgb [4] = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
  logic [27:0] pre_w   [4] = '{{7'h00, 7'h4C, 7'h71, 7'h11},
                               {7'h15, 7'h49, 7'h4A, 7'h44},
                               {7'h29, 7'h46, 7'h24, 7'h37},
                               {7'h3A, 7'h43, 7'h1D, 7'h6A}};

  function automatic logic [23:0] stream_rgb(input int i);
    logic [31:0] t;
    t = i * 32'h0001_0307;
    return t[23:0] ^ 24'h5A5A5A;
  endfunction

  initial begin
    bit acc;
    int i;
    int guard;
    logic hs, vs;

    // Reset, then idle through TRAIN into blanking.
    for (int k = 0; k < 3; k++) drive(1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0, 1'b1, acc);
    idle(1);
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
    idle(12);

    // Retrain, then preload during TRAIN until the FIFO is full.
    drive(1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 28'd0, 1'b1, 1'b0, acc);
    chk("in_ready_during_retrain", {31'd0, in_ready}, 32'd0);
    for (int p = 0; p < 4; p++) begin
      drive(1'b1, pre_rgb[p], 1'b0, 1'b0, 1'b1, pre_w[p], 1'b0, 1'b0, acc);
      chk("preload_accept", {31'd0, acc}, 32'd1);
    end
    drive(1'b1, 24'hDDEEFF, 1'b0, 1'b0, 1'b1, model_pack(24'hDDEEFF, 1'b0, 1'b0, 1'b1),
          1'b0, 1'b0, acc);
    chk("in_ready_full", {31'd0, in_ready}, 32'd0);
    chk("no_push_when_full", {31'd0, acc}, 32'd0);
    idle(10);

    // Retrain, then stream 1000 pixels with in_valid held high; the last has HS=1 VS=0.
    drive(1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 28'd0, 1'b1, 1'b0, acc);
    i = 0;
    guard = 0;
    while (i < 1000 && guard < 2000) begin
      hs = (i == 999) ? 1'b1 : ((i % 10) == 0);
      vs = (i == 999) ? 1'b0 : (i < 3);
      drive(1'b1, stream_rgb(i), hs, vs, 1'b1, model_pack(stream_rgb(i), hs, vs, 1'b1),
            1'b0, 1'b0, acc);
      if (acc) i++;
      guard++;
    end
    chk("stream_count", i, 1000);
    idle(8);
    chk("stream_drained", sb.size(), 0);

    // Retrain while a pixel is waiting in the FIFO and another is offered.
    drive(1'b1, 24'h123456, 1'b0, 1'b0, 1'b1, model_pack(24'h123456, 1'b0, 1'b0, 1'b1),
          1'b0, 1'b0, acc);
    chk("pre_retrain_accept", {31'd0, acc}, 32'd1);
    drive(1'b1, 24'h654321, 1'b1, 1'b1, 1'b1, model_pack(24'h654321, 1'b1, 1'b1, 1'b1),
          1'b1, 1'b0, acc);
    chk("in_ready_retrain_busy", {31'd0, in_ready}, 32'd0);
    idle(12);

    // Stream a few pixels, then pulse RSTB with the FIFO occupied.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, stream_rgb(k + 7), 1'b0, 1'b1, 1'b1,
            model_pack(stream_rgb(k + 7), 1'b0, 1'b1, 1'b1), 1'b0, 1'b0, acc);
    end
    drive(1'b1, 24'hFFFFFF, 1'b1, 1'b1, 1'b1, model_pack(24'hFFFFFF, 1'b1, 1'b1, 1'b1),
          1'b0, 1'b1, acc);
    chk("no_push_in_reset", {31'd0, acc}, 32'd0);
    idle(14);
    chk("final_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lvds71_tx_framer.md
# lvds71_tx_framer

Pixel-to-lane framer for the 7:1 LVDS transmit path. Accepts 24-bit RGB pixels with HS/VS/DE through a valid/ready handshake, buffers them in a small FIFO, and packs each pixel into four 7-bit data-lane words plus the clock-lane word. After reset or on request, it emits a fixed training word. Its outputs feed one 7:1 output serializer per lane directly, in the SCLK domain, with bit k of each lane word driving serializer input Dk (D0 is serialized first).

## Interface
- FIFO_DEPTH, 4: pixel FIFO entries; power of two, 2..16.
- TRAIN_CYCLES, 1024: SCLK cycles spent in TRAIN; minimum 1.
- TRAIN_WORD, 7'b1100011: data-lane word emitted while training.
- SCLK  in  1  word clock; same clock as the serializers' SCLK.
- RSTB  in  1  reset, synchronous, active-high.
- retrain  in  1  single-cycle request to flush and re-enter TRAIN.
- in_valid  in  1  pixel valid.
- in_ready  out  1  pixel accept; equals !full & !retrain.
- in_rgb  in  24  {R[7:0],G[7:0],B[7:0]}.
- in_hs, in_vs, in_de  in  1 each  sync and data-enable.
- txd0..txd3  out  7 each  registered data-lane words.
- txclk  out  7  registered clock-lane word; constant 7'b1100011.
- trained  out  1  high in RUN.
- underflow  out  1  sticky; set when RUN finds the FIFO empty.

## Operation
- Lane packing for a pixel, listed as bits D0..D6:
  - txd0 = R0 R1 R2 R3 R4 R5 G0
  - txd1 = G1 G2 G3 G4 G5 B0 B1
  - txd2 = B2 B3 B4 B5 HS VS DE
  - txd3 = R6 R7 G6 G7 B6 B7 0
- FIFO behaviour:
  - A push happens on an edge where in_valid & in_ready.
  - Nothing is pushed while full, even if a pop occurs in the same cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide with wrap bit. Full is indicated when addresses are equal and wrap bits differ; empty when pointers are equal.
- States are TRAIN and RUN.
- TRAIN:
  - txd0..3 = TRAIN_WORD and trained = 0.
  - The counter counts from 0. On the edge where the counter equals TRAIN_CYCLES-1, the state moves to RUN.
  - The FIFO may fill during TRAIN. No pops occur.
- RUN:
  - On every edge, if the FIFO is not empty, the head is popped and its packed words are loaded into the txd registers. The HS/VS values are stored as last_hs/last_vs.
  - If the FIFO is empty, the block loads a blanking word (RGB=0, DE=0, HS=last_hs, VS=last_vs) and sets underflow.
- retrain, sampled on the edge, has these effects:
  - The FIFO is flushed and the counter is cleared.
  - The state moves to TRAIN and underflow is cleared.
  - last_hs/last_vs are cleared to 0.
  - retrain takes priority over a push or pop in the same cycle. in_ready is forced low, so no pixel is lost silently.
- txclk ignores state and is always 7'b1100011.

## Timing
- Reset values (RSTB high at an edge):
  - state = TRAIN, counter = 0, FIFO empty.
  - txd0..3 = TRAIN_WORD, txclk = 7'b1100011.
  - trained = 0, underflow = 0, last_hs = last_vs = 0.
  - in_ready = 1 from the first cycle after reset.
- If RSTB is asserted mid-RUN, the next edge gives the reset state. FIFO contents are discarded.
- Training length: the first RUN-loaded word appears after edge TRAIN_CYCLES (counting the first post-reset edge as 1). trained rises on that same edge.
- Latency in RUN: a pixel pushed at edge k into an empty FIFO is popped and registered at edge k+1. It is visible on txd from k+1.
- Throughput is one pixel per SCLK. A continuous stream with in_valid held high never underflows once the FIFO holds at least 1 entry at RUN entry.
- underflow is set at the edge that loads a blanking word. It holds until reset or retrain.
- If retrain is asserted in TRAIN, the counter restarts from 0.

## Test plan
- Reset then idle, TRAIN_CYCLES=8: txd0..3 = 7'b1100011 for the first 8 edges. trained rises after edge 8, then blanking words follow with underflow=1. txclk stays constant throughout.
- Preload during TRAIN, FIFO_DEPTH=4, pixels 0x112233/0x445566/0x778899/0xAABBCC with DE=1: in_ready drops after the 4th push. In RUN the words appear in order on consecutive edges. For 0x112233, txd0 bits D0..D6 = 1,0,0,0,1,0,0.
- Streaming in RUN, in_valid held high: 1000 pixels output with no gaps. underflow stays 0 after its initial clear. Each pixel appears 1 edge after acceptance.
- Underflow hold, last pixel HS=1 VS=0, then stall: the blanking word has txd2 D4=1, D5=0, D6=0 and RGB lanes zero. underflow latches to 1.
- retrain coinciding with in_valid and a non-empty FIFO: in_ready=0 that cycle, the FIFO becomes empty, and the next 8 words are TRAIN_WORD. trained=0 and underflow=0.
- RSTB pulsed mid-stream: the next edge shows txd=TRAIN_WORD, trained=0, FIFO empty. Pixels queued before reset are never emitted.
